// File: rtl/ep_fifo_pkg.sv
// rtl/ep_fifo_pkg.sv - shared constants and width helpers for the endpoint FIFO RAM
//
// Default geometry of the endpoint FIFO block and the log2 helper used to
// derive pointer and occupancy widths from it.
//   DEF_DATA_W   : default payload word width
//   DEF_NUM_EP   : default number of endpoint channels
//   DEF_EP_DEPTH : default entries per endpoint
//   clog2()      : ceiling log2, usable in constant expressions
//   ptr_w()      : pointer width for a given per-endpoint depth
//   cnt_w()      : occupancy width (one extra bit so "full" is representable)
package ep_fifo_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_EP   = 4;
    localparam int DEF_EP_DEPTH = 16;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int ptr_w(input int depth);
        return clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ep_ram_sdp.sv
// rtl/ep_ram_sdp.sv - simple-dual-port RAM with one write port and one registered read port
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (read data register only)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; rdata updates one edge later, holds otherwise
//   raddr  : read address
//   rdata  : registered read data
//
// Storage is never reset. A read and a write to the same address in the same
// cycle return the old contents (read-before-write), which the FIFO relies on
// when a full endpoint is pushed and popped together.
module ep_ram_sdp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ep_fifo_ram.sv
// rtl/ep_fifo_ram.sv - shared RAM partitioned into NUM_EP independent ring FIFOs
//
// Optional feature macro: EP_BYPASS_EN (forward a push straight to the output
// when it meets a pop on the same, empty endpoint).
//
// Ports:
//   Clock        : rising-edge clock
//   Reset        : asynchronous active-low reset
//   iWriteEnable : push request
//   iWriteEp     : endpoint targeted by the push
//   iDataIn      : push data
//   iReadEnable  : pop request
//   iReadEp      : endpoint to pop
//   iFlush       : flush request
//   iFlushEp     : endpoint to flush
//   oDataOut0    : popped data, valid the cycle after an accepted pop, held otherwise
//   oDataValid   : oDataOut0 carries freshly popped data this cycle
//   oFull        : per-endpoint full flag
//   oEmpty       : per-endpoint empty flag
//   oCount       : packed occupancy, endpoint k at [k*CNT_W +: CNT_W]
//   oWriteErr    : one-cycle pulse, a push was rejected because the endpoint was full
//   oReadErr     : one-cycle pulse, a pop was rejected because the endpoint was empty
module ep_fifo_ram
    import ep_fifo_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_EP   = DEF_NUM_EP,
    parameter  int EP_DEPTH = DEF_EP_DEPTH,
    localparam int EP_W     = clog2(NUM_EP),
    localparam int PTR_W    = ptr_w(EP_DEPTH),
    localparam int CNT_W    = cnt_w(EP_DEPTH)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iWriteEnable,
    input  logic [EP_W-1:0]         iWriteEp,
    input  logic [DATA_W-1:0]       iDataIn,
    input  logic                    iReadEnable,
    input  logic [EP_W-1:0]         iReadEp,
    input  logic                    iFlush,
    input  logic [EP_W-1:0]         iFlushEp,
    output logic [DATA_W-1:0]       oDataOut0,
    output logic                    oDataValid,
    output logic [NUM_EP-1:0]       oFull,
    output logic [NUM_EP-1:0]       oEmpty,
    output logic [NUM_EP*CNT_W-1:0] oCount,
    output logic                    oWriteErr,
    output logic                    oReadErr
);

    localparam int ADDR_W = EP_W + PTR_W;

    logic [PTR_W-1:0] wptr    [NUM_EP];
    logic [PTR_W-1:0] rptr    [NUM_EP];
    logic [CNT_W-1:0] cnt     [NUM_EP];
    logic [CNT_W-1:0] cnt_nxt [NUM_EP];

    logic flush_w;
    logic flush_r;
    logic same_ep;
    logic pop_ok;
    logic push_ok;
    logic fwd;
    logic werr_nxt;
    logic rerr_nxt;
    logic ram_we;
    logic [DATA_W-1:0] ram_q;

    // Request qualification. A flush on an endpoint swallows any push or pop
    // to that endpoint in the same cycle without raising an error.
    always_comb begin
        flush_w = iFlush && (iFlushEp == iWriteEp);
        flush_r = iFlush && (iFlushEp == iReadEp);
        same_ep = (iWriteEp == iReadEp);
        pop_ok  = iReadEnable && !oEmpty[iReadEp] && !flush_r;
        // A full endpoint still takes a push when it is popped in the same cycle.
        push_ok = iWriteEnable && !flush_w && (!oFull[iWriteEp] || (pop_ok && same_ep));
`ifdef EP_BYPASS_EN
        fwd     = iReadEnable && push_ok && same_ep && oEmpty[iReadEp] && !flush_r;
`else
        fwd     = 1'b0;
`endif
        werr_nxt = iWriteEnable && !flush_w && !push_ok;
        rerr_nxt = iReadEnable && !flush_r && oEmpty[iReadEp] && !fwd;
        // Forwarded data never touches the RAM.
        ram_we   = push_ok && !fwd;
    end

    always_comb begin
        for (int k = 0; k < NUM_EP; k++) begin
            cnt_nxt[k] = cnt[k];
            if (iFlush && (iFlushEp == EP_W'(k))) begin
                cnt_nxt[k] = '0;
            end else begin
                case ({ram_we && (iWriteEp == EP_W'(k)), pop_ok && (iReadEp == EP_W'(k))})
                    2'b10:   cnt_nxt[k] = cnt[k] + CNT_W'(1);
                    2'b01:   cnt_nxt[k] = cnt[k] - CNT_W'(1);
                    default: cnt_nxt[k] = cnt[k];
                endcase
            end
        end
    end

    // Pointers wrap naturally because EP_DEPTH is a power of two. On a
    // forwarded transfer both pointers advance so they stay equal (empty).
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < NUM_EP; k++) begin
                wptr[k] <= '0;
                rptr[k] <= '0;
                cnt[k]  <= '0;
            end
            oFull  <= '0;
            oEmpty <= '1;
        end else begin
            for (int k = 0; k < NUM_EP; k++) begin
                if (iFlush && (iFlushEp == EP_W'(k))) begin
                    wptr[k] <= '0;
                    rptr[k] <= '0;
                end else begin
                    if (push_ok && (iWriteEp == EP_W'(k))) begin
                        wptr[k] <= wptr[k] + PTR_W'(1);
                    end
                    if ((pop_ok || fwd) && (iReadEp == EP_W'(k))) begin
                        rptr[k] <= rptr[k] + PTR_W'(1);
                    end
                end
                cnt[k]    <= cnt_nxt[k];
                oFull[k]  <= (cnt_nxt[k] == CNT_W'(EP_DEPTH));
                oEmpty[k] <= (cnt_nxt[k] == '0);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oDataValid <= 1'b0;
            oWriteErr  <= 1'b0;
            oReadErr   <= 1'b0;
        end else begin
            oDataValid <= pop_ok || fwd;
            oWriteErr  <= werr_nxt;
            oReadErr   <= rerr_nxt;
        end
    end

    ep_ram_sdp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (Clock),
        .rst_n (Reset),
        .we    (ram_we),
        .waddr ({iWriteEp, wptr[iWriteEp]}),
        .wdata (iDataIn),
        .re    (pop_ok),
        .raddr ({iReadEp, rptr[iReadEp]}),
        .rdata (ram_q)
    );

`ifdef EP_BYPASS_EN
    // Output source select: the last transfer decides whether the held value
    // comes from the RAM read register or the forwarding register.
    logic              byp_sel;
    logic [DATA_W-1:0] byp_data;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            byp_sel  <= 1'b0;
            byp_data <= '0;
        end else if (fwd) begin
            byp_sel  <= 1'b1;
            byp_data <= iDataIn;
        end else if (pop_ok) begin
            byp_sel  <= 1'b0;
        end
    end

    assign oDataOut0 = byp_sel ? byp_data : ram_q;
`else
    assign oDataOut0 = ram_q;
`endif

    always_comb begin
        oCount = '0;
        for (int k = 0; k < NUM_EP; k++) begin
            oCount[k*CNT_W +: CNT_W] = cnt[k];
        end
    end

endmodule

// File: tb/tb_ep_fifo_ram.sv
// tb/tb_ep_fifo_ram.sv - self-checking bench for ep_fifo_ram against a queue model
module tb_ep_fifo_ram;

    localparam int DW  = 8;
    localparam int NE  = 4;
    localparam int DEP = 16;
    localparam int EW  = 2;
    localparam int CW  = 5;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          iWriteEnable = 1'b0;
    logic [EW-1:0] iWriteEp = '0;
    logic [DW-1:0] iDataIn = '0;
    logic          iReadEnable = 1'b0;
    logic [EW-1:0] iReadEp = '0;
    logic          iFlush = 1'b0;
    logic [EW-1:0] iFlushEp = '0;
    logic [DW-1:0] oDataOut0;
    logic          oDataValid;
    logic [NE-1:0] oFull;
    logic [NE-1:0] oEmpty;
    logic [NE*CW-1:0] oCount;
    logic          oWriteErr;
    logic          oReadErr;

    ep_fifo_ram #(.DATA_W(DW), .NUM_EP(NE), .EP_DEPTH(DEP)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iWriteEnable (iWriteEnable),
        .iWriteEp     (iWriteEp),
        .iDataIn      (iDataIn),
        .iReadEnable  (iReadEnable),
        .iReadEp      (iReadEp),
        .iFlush       (iFlush),
        .iFlushEp     (iFlushEp),
        .oDataOut0    (oDataOut0),
        .oDataValid   (oDataValid),
        .oFull        (oFull),
        .oEmpty       (oEmpty),
        .oCount       (oCount),
        .oWriteErr    (oWriteErr),
        .oReadErr     (oReadErr)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: one queue per endpoint plus the expected registered outputs.
    int        mq [NE][$];
    logic [DW-1:0] e_data = '0;
    bit        e_valid = 1'b0;
    bit        e_werr = 1'b0;
    bit        e_rerr = 1'b0;
    bit        m_fw, m_fr, m_pa, m_wa, m_fwd;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < NE; k++) mq[k].delete();
            e_data  = '0;
            e_valid = 1'b0;
            e_werr  = 1'b0;
            e_rerr  = 1'b0;
        end else begin
            m_fw  = iFlush && (iFlushEp == iWriteEp);
            m_fr  = iFlush && (iFlushEp == iReadEp);
            m_pa  = iReadEnable && !m_fr && (mq[iReadEp].size() > 0);
            m_wa  = iWriteEnable && !m_fw &&
                    ((mq[iWriteEp].size() < DEP) || (m_pa && (iReadEp == iWriteEp)));
            m_fwd = 1'b0;
`ifdef EP_BYPASS_EN
            m_fwd = iReadEnable && m_wa && !m_fr && (iReadEp == iWriteEp) &&
                    (mq[iReadEp].size() == 0);
`endif
            e_werr  = iWriteEnable && !m_fw && !m_wa;
            e_rerr  = iReadEnable && !m_fr && !m_pa && !m_fwd;
            e_valid = m_pa || m_fwd;
            if (m_pa) e_data = DW'(mq[iReadEp].pop_front());
            else if (m_fwd) e_data = iDataIn;
            if (m_wa && !m_fwd) mq[iWriteEp].push_back(int'(iDataIn));
            if (iFlush) mq[iFlushEp].delete();
        end
    end

    // Single compare process: every falling edge, all outputs against the model.
    always @(negedge Clock) begin
        logic [NE-1:0] ef, ee;
        for (int k = 0; k < NE; k++) begin
            ef[k] = (mq[k].size() == DEP);
            ee[k] = (mq[k].size() == 0);
            check($sformatf("count%0d", k), 32'(oCount[k*CW +: CW]), 32'(mq[k].size()));
        end
        check("full", 32'(oFull), 32'(ef));
        check("empty", 32'(oEmpty), 32'(ee));
        check("valid", 32'(oDataValid), 32'(e_valid));
        check("data", 32'(oDataOut0), 32'(e_data));
        check("werr", 32'(oWriteErr), 32'(e_werr));
        check("rerr", 32'(oReadErr), 32'(e_rerr));
    end

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic drive(input bit we, input int wep, input int din,
                         input bit re, input int rep);
        iWriteEnable = we;
        iWriteEp     = EW'(wep);
        iDataIn      = DW'(din);
        iReadEnable  = re;
        iReadEp      = EW'(rep);
        iFlush       = 1'b0;
        tick();
    endtask

    function automatic int cnt_of(input int k);
        return int'(oCount[k*CW +: CW]);
    endfunction

    initial begin
        // Reset state
        @(negedge Clock);
        @(negedge Clock);
        check("rst_empty", 32'(oEmpty), 32'hF);
        check("rst_full", 32'(oFull), 32'h0);
        check("rst_count", 32'(oCount), 32'h0);
        check("rst_valid", 32'(oDataValid), 32'h0);
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
        check("idle_empty", 32'(oEmpty), 32'hF);

        // Basic FIFO order on ep2
        drive(1, 2, 8'hA1, 0, 0);
        drive(1, 2, 8'hA2, 0, 0);
        drive(1, 2, 8'hA3, 0, 0);
        check("ep2_cnt3", 32'(cnt_of(2)), 32'd3);
        drive(0, 0, 0, 1, 2);
        check("pop_a1", 32'(oDataOut0), 32'hA1);
        check("pop_a1_v", 32'(oDataValid), 32'd1);
        drive(0, 0, 0, 1, 2);
        check("pop_a2", 32'(oDataOut0), 32'hA2);
        drive(0, 0, 0, 1, 2);
        check("pop_a3", 32'(oDataOut0), 32'hA3);
        drive(0, 0, 0, 0, 0);
        check("ep2_empty", 32'(oEmpty[2]), 32'd1);
        check("hold_a3", 32'(oDataOut0), 32'hA3);

        // Fill ep1, overflow, push+pop while full
        for (int i = 0; i < DEP; i++) drive(1, 1, 8'h10 + i, 0, 0);
        check("ep1_full", 32'(oFull[1]), 32'd1);
        check("ep1_cnt16", 32'(cnt_of(1)), 32'd16);
        drive(1, 1, 8'hEE, 0, 0);
        check("ovf_werr", 32'(oWriteErr), 32'd1);
        check("ovf_cnt", 32'(cnt_of(1)), 32'd16);
        drive(1, 1, 8'h77, 1, 1);
        check("full_pp_data", 32'(oDataOut0), 32'h10);
        check("full_pp_cnt", 32'(cnt_of(1)), 32'd16);
        check("full_pp_werr", 32'(oWriteErr), 32'd0);

        // Empty pop on ep3, then pop+push on empty ep3
        drive(0, 0, 0, 1, 3);
        check("udf_rerr", 32'(oReadErr), 32'd1);
        check("udf_valid", 32'(oDataValid), 32'd0);
        drive(1, 3, 8'h5C, 1, 3);
`ifdef EP_BYPASS_EN
        check("byp_data", 32'(oDataOut0), 32'h5C);
        check("byp_valid", 32'(oDataValid), 32'd1);
        check("byp_cnt", 32'(cnt_of(3)), 32'd0);
        check("byp_rerr", 32'(oReadErr), 32'd0);
`else
        check("pp_empty_rerr", 32'(oReadErr), 32'd1);
        check("pp_empty_cnt", 32'(cnt_of(3)), 32'd1);
        drive(0, 0, 0, 1, 3);
        check("ep3_data", 32'(oDataOut0), 32'h5C);
`endif
        drive(0, 0, 0, 0, 0);

        // Drain ep1 down to 3 words, then wrap ep0 with interleaved traffic
        for (int i = 0; i < 13; i++) drive(0, 0, 0, 1, 1);
        check("ep1_cnt3", 32'(cnt_of(1)), 32'd3);
        for (int i = 0; i < 20; i++) drive(1, 0, 8'hC0 + i, (i >= 2), 0);
        check("ep0_wrap_cnt", 32'(cnt_of(0)), 32'd2);
        check("ep1_still3", 32'(cnt_of(1)), 32'd3);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        check("ep0_last", 32'(oDataOut0), 32'hD3);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1);
        check("ep1_last", 32'(oDataOut0), 32'h77);

        // Flush ep0 holding 5 words while a push to ep0 arrives
        for (int i = 0; i < 5; i++) drive(1, 0, 8'h31 + i, 0, 0);
        iWriteEnable = 1'b1; iWriteEp = 2'd0; iDataIn = 8'h99;
        iReadEnable  = 1'b0;
        iFlush = 1'b1; iFlushEp = 2'd0;
        tick();
        iFlush = 1'b0;
        check("flush_cnt", 32'(cnt_of(0)), 32'd0);
        check("flush_empty", 32'(oEmpty[0]), 32'd1);
        check("flush_werr", 32'(oWriteErr), 32'd0);

        // Reset in the middle of a pop
        drive(1, 0, 8'h41, 0, 0);
        drive(1, 0, 8'h42, 0, 0);
        iWriteEnable = 1'b0;
        iReadEnable  = 1'b1; iReadEp = 2'd0;
        @(posedge Clock);
        #1;
        check("mid_valid_pre", 32'(oDataValid), 32'd1);
        Reset = 1'b0;
        #1;
        check("mid_valid_rst", 32'(oDataValid), 32'd0);
        check("mid_count_rst", 32'(oCount), 32'd0);
        iReadEnable = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("post_rst_empty", 32'(oEmpty), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ep_fifo_ram.md
Name: ep_fifo_ram

Overview:
- Parametrised successor of the single-port endpoint RAM: one shared simple-dual-port memory partitioned into NUM_EP independent ring FIFOs, one per USB endpoint.
- Sits between the packet decoder (writes payload bytes tagged with endpoint number) and the endpoint/host-side reader.
- Adds per-endpoint pointers, occupancy, full/empty flags, flush and error reporting, none of which the plain RAM has.

Parameters:
- DATA_W, 8, payload word width.
- NUM_EP, 4, number of endpoint channels (power of 2, ≥2).
- EP_DEPTH, 16, entries per endpoint (power of 2, ≥2).
- Derived, not overridable: EP_W = clog2(NUM_EP), PTR_W = clog2(EP_DEPTH), CNT_W = PTR_W+1.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- iWriteEnable  in  1  push request.
- iWriteEp  in  EP_W  target endpoint of push.
- iDataIn  in  DATA_W  push data.
- iReadEnable  in  1  pop request.
- iReadEp  in  EP_W  endpoint to pop.
- iFlush  in  1  flush request.
- iFlushEp  in  EP_W  endpoint to flush.
- oDataOut0  out  DATA_W  popped data, registered.
- oDataValid  out  1  oDataOut0 valid this cycle.
- oFull  out  NUM_EP  per-endpoint full flag.
- oEmpty  out  NUM_EP  per-endpoint empty flag.
- oCount  out  NUM_EP*CNT_W  packed occupancy; ep k at bits [k*CNT_W +: CNT_W].
- oWriteErr  out  1  one-cycle pulse: push rejected (full).
- oReadErr  out  1  one-cycle pulse: pop rejected (empty).

Behaviour:
- Reset (async assert, sync release): all write/read pointers and counts 0; oEmpty all 1; oFull 0; oCount 0; oDataOut0 0; oDataValid 0; oWriteErr/oReadErr 0. RAM contents not reset.
- Physical address = {ep, ptr}; RAM depth NUM_EP*EP_DEPTH.
- Flags: oFull[k] = (count[k]==EP_DEPTH); oEmpty[k] = (count[k]==0). Both registered and consistent with oCount.
- Push accepted if iWriteEnable and (not full[iWriteEp], or a pop accepted on the same ep this cycle). Writes RAM at wptr, wptr wraps modulo EP_DEPTH, count+1.
- Pop accepted if iReadEnable and not empty[iReadEp]. RAM read at rptr, rptr wraps, count-1.
- Read latency 1: oDataOut0 and oDataValid=1 the cycle after an accepted pop. oDataValid=0 otherwise; oDataOut0 holds its last value.
- Push and pop on the same ep in one cycle: both accepted (full case included), count unchanged.
- Pop on empty ep with simultaneous push to same ep: pop rejected, oReadErr=1, push accepted (unless EP_BYPASS_EN).
- Push and pop on different eps are fully independent.
- Flush: at the next edge, wptr, rptr and count of iFlushEp are set to 0. Push/pop to the same ep that cycle are dropped, with no error pulse and no oDataValid. Other eps unaffected.
- Error pulses registered: asserted exactly one cycle after the rejected request. Counts never wrap, never exceed EP_DEPTH, never go below 0.
- Reset mid-operation: immediate return to reset state; an in-flight oDataValid is cancelled.

Optional Feature:
- Macro EP_BYPASS_EN.
- Defined: a pop to an empty ep with a simultaneous accepted push to the same ep is forwarded. Next cycle oDataOut0 = iDataIn and oDataValid=1; no RAM write, pointers advance together, count stays 0, no oReadErr.
- Undefined: behaviour as in Behaviour (pop rejected, oReadErr).

Decomposition:
- Package ep_fifo_pkg: default DATA_W/NUM_EP/EP_DEPTH constants, clog2 function, CNT_W/PTR_W derivation.
- One sub-module ep_ram_sdp: simple-dual-port RAM, one write port and one registered read port, DATA_W x NUM_EP*EP_DEPTH, no reset on storage.
- Pointers, counters, flags and error logic stay in the top.

Test Plan:
- Reset → oEmpty=4'b1111, oFull=0, oCount=0, oDataValid=0. Release, idle 5 cycles → unchanged.
- Push 0xA1,0xA2,0xA3 to ep2, then pop ep2 ×3 → oDataOut0 = A1,A2,A3 on the cycles after each pop, oDataValid high 3 cycles, oEmpty[2]=1 at end.
- Push 16 words to ep1 → oFull[1]=1, count=16. 17th push → oWriteErr pulse, count stays 16. Push+pop ep1 same cycle → both accepted, count 16.
- Pop empty ep3 → oReadErr pulse 1 cycle, oDataValid=0. With EP_BYPASS_EN, pop+push 0x5C ep3 → oDataOut0=0x5C, oDataValid=1, count 0.
- Fill ep0 with 20 pushes/pops interleaved (wrap) while ep1 holds 3 words → FIFO order preserved on both; ep1 count 3 throughout.
- ep0 holds 5 words; flush ep0 with simultaneous push ep0 → count 0, oEmpty[0]=1, no oWriteErr. Assert Reset mid-pop → oDataValid=0 immediately.
